prod_accum: RTL and testbench

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_accum.sv | 146 ++++++++++++++
 tb/tb_prod_accum.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - frame accumulator for signed 28-bit multiplier products
// Sums LEN products with saturation and holds the result until the consumer takes it.
module prod_accum #(
    parameter int LEN   = 8,
    parameter int ACC_W = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [27:0]      prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             sat,
    output logic [4:0]       cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [4:0] LEN_M1 = 5'(LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_sum;
    logic             r_sum_valid;
    logic             r_prod_ready;
    logic             r_sat;
    logic [4:0]       r_cnt;

    logic             w_prod_hs;
    logic             w_sum_hs;
    logic             w_first;
    logic             w_last;
    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W:0]   w_wide;
    logic             w_pos_ovf;
    logic             w_neg_ovf;
    logic [ACC_W-1:0] w_acc_clamped;
    logic [ACC_W-1:0] w_acc_load;

    assign w_prod_hs = prod_valid && r_prod_ready;
    assign w_sum_hs  = r_sum_valid && sum_ready;
    assign w_first   = (r_state == IDLE);
    assign w_last    = w_prod_hs && (w_first ? (LEN == 1) : (r_cnt == LEN_M1));

    // One extra bit of headroom: the top two bits disagree exactly when the add overflowed.
    assign w_prod_ext = ACC_W'($signed(prod));
    assign w_wide     = (ACC_W+1)'($signed(r_acc)) + (ACC_W+1)'($signed(prod));
    assign w_pos_ovf  = !w_wide[ACC_W] &&  w_wide[ACC_W-1];
    assign w_neg_ovf  =  w_wide[ACC_W] && !w_wide[ACC_W-1];

    always_comb begin
        w_acc_clamped = w_wide[ACC_W-1:0];
        if (w_pos_ovf) begin
            w_acc_clamped = ACC_MAX;
        end else if (w_neg_ovf) begin
            w_acc_clamped = ACC_MIN;
        end
    end

    assign w_acc_load = w_first ? w_prod_ext : w_acc_clamped;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_prod_hs) begin
                    w_state_next = w_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_last) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (w_sum_hs) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (clear) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_sum        <= '0;
            r_sum_valid  <= 1'b0;
            r_prod_ready <= 1'b0;
            r_sat        <= 1'b0;
            r_cnt        <= 5'd0;
        end else begin
            r_state      <= w_state_next;
            r_prod_ready <= (w_state_next != HOLD);
            if (clear) begin
                r_acc       <= '0;
                r_sum_valid <= 1'b0;
                r_sat       <= 1'b0;
                r_cnt       <= 5'd0;
            end else begin
                if (w_prod_hs) begin
                    r_acc <= w_acc_load;
                    if (w_first) begin
                        r_cnt <= 5'd1;
                        r_sat <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                        if (w_pos_ovf || w_neg_ovf) begin
                            r_sat <= 1'b1;
                        end
                    end
                end
                if (w_last) begin
                    r_sum       <= w_acc_load;
                    r_sum_valid <= 1'b1;
                end
                // cnt stays at LEN while the sum is held, then drops back for the next frame.
                if (w_sum_hs) begin
                    r_sum_valid <= 1'b0;
                    r_cnt       <= 5'd0;
                end
            end
        end
    end

    assign prod_ready = r_prod_ready;
    assign sum        = r_sum;
    assign sum_valid  = r_sum_valid;
    assign sat        = r_sat;
    assign cnt        = r_cnt;

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - scoreboard bench for prod_accum
module tb_prod_accum;

    localparam int LEN   = 8;
    localparam int ACC_W = 30;
    localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_W-1));

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [27:0]      prod = '0;
    logic             prod_valid = 1'b0;
    logic             prod_ready;
    logic             clear = 1'b0;
    logic [ACC_W-1:0] sum;
    logic             sum_valid;
    logic             sum_ready = 1'b0;
    logic             sat;
    logic [4:0]       cnt;

    prod_accum #(.LEN(LEN), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .clear      (clear),
        .sum        (sum),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sat        (sat),
        .cnt        (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic             sat;
    } exp_t;

    exp_t   sb[$];
    longint m_acc = 0;
    int     m_cnt = 0;
    logic   m_sat = 1'b0;
    int     n_checks = 0;
    int     n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_add(input logic [27:0] p);
        longint v;
        longint s;
        v = longint'($signed(p));
        if (m_cnt == 0) begin
            m_acc = v;
            m_sat = 1'b0;
        end else begin
            s = m_acc + v;
            if (s > MAXV) begin
                s = MAXV;
                m_sat = 1'b1;
            end else if (s < MINV) begin
                s = MINV;
                m_sat = 1'b1;
            end
            m_acc = s;
        end
        m_cnt++;
        if (m_cnt == LEN) begin
            sb.push_back('{ACC_W'(m_acc), m_sat});
        end
    endfunction

    task automatic push_prod(input logic [27:0] p);
        int w;
        w = 0;
        prod = p;
        prod_valid = 1'b1;
        while (!prod_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!prod_ready) begin
            check("prod_ready_timeout", 64'(prod_ready), 64'd1);
            prod_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_add(p);
            @(negedge clk);
            prod_valid = 1'b0;
            check("cnt_after_hs", 64'(cnt), 64'(m_cnt));
        end
    endtask

    task automatic take_sum(input int hold_cycles);
        exp_t e;
        e.sum = '0;
        e.sat = 1'b0;
        check("sum_valid_latency", 64'(sum_valid), 64'd1);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
        end
        check("sum", 64'(sum), 64'(e.sum));
        check("sat", 64'(sat), 64'(e.sat));
        for (int i = 0; i < hold_cycles; i++) begin
            prod_valid = 1'($urandom);
            prod = 28'($urandom);
            @(negedge clk);
            check("hold_sum", 64'(sum), 64'(e.sum));
            check("hold_sum_valid", 64'(sum_valid), 64'd1);
            check("hold_prod_ready", 64'(prod_ready), 64'd0);
            check("hold_cnt", 64'(cnt), 64'(LEN));
            check("hold_sat", 64'(sat), 64'(e.sat));
        end
        prod_valid = 1'b0;
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        m_cnt = 0;
        check("release_sum_valid", 64'(sum_valid), 64'd0);
        check("release_prod_ready", 64'(prod_ready), 64'd1);
        check("release_cnt", 64'(cnt), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_prod_ready", 64'(prod_ready), 64'd0);
        check("rst_sum_valid", 64'(sum_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_sat", 64'(sat), 64'd0);
        check("rst_cnt", 64'(cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_edge_prod_ready", 64'(prod_ready), 64'd1);

        // sequential 1..8
        for (int i = 1; i <= LEN; i++) push_prod(28'(i));
        take_sum(0);

        // positive saturation
        for (int i = 0; i < LEN; i++) push_prod(28'h4000000);
        take_sum(0);

        // negative boundary, exact
        for (int i = 0; i < LEN; i++) push_prod(28'hC000000);
        take_sum(0);

        // backpressure for 5 cycles
        for (int i = 0; i < LEN; i++) push_prod(28'($urandom_range(0, 1000)));
        take_sum(5);

        // asynchronous reset mid-frame
        for (int i = 1; i <= 3; i++) push_prod(28'(i * 7));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sum", 64'(sum), 64'd0);
        check("async_rst_cnt", 64'(cnt), 64'd0);
        check("async_rst_prod_ready", 64'(prod_ready), 64'd0);
        check("async_rst_sum_valid", 64'(sum_valid), 64'd0);
        check("async_rst_sat", 64'(sat), 64'd0);
        m_cnt = 0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= LEN; i++) push_prod(28'(i));
        take_sum(0);

        // clear with coincident product
        for (int i = 0; i < 5; i++) push_prod(28'h7FFFFFF);
        clear = 1'b1;
        prod_valid = 1'b1;
        prod = 28'd99;
        @(negedge clk);
        clear = 1'b0;
        prod_valid = 1'b0;
        m_cnt = 0;
        check("clear_cnt", 64'(cnt), 64'd0);
        check("clear_sat", 64'(sat), 64'd0);
        check("clear_sum_valid", 64'(sum_valid), 64'd0);
        check("clear_prod_ready", 64'(prod_ready), 64'd1);
        for (int i = 0; i < LEN; i++) push_prod(28'd2);
        take_sum(0);

        // random frames, large magnitudes exercise both clamps
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < LEN; i++) push_prod(28'($urandom));
            take_sum(int'($urandom_range(0, 3)));
        end

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
